// File: rtl/loss_min_tracker_if.sv
// loss_min_tracker_if
// Groups the sweep-control and loss-result signals of loss_min_tracker.
//   master : sweep controller / loss stage side (drives start, n_cand,
//            loss_valid, loss_in; observes the results)
//   slave  : the tracker itself
// Signals:
//   start, n_cand         sweep start pulse and candidate count
//   loss_valid, loss_in   result strobe and 3Qp loss word
//   sweep_active, best_loss, best_idx, result_cnt, done, sat_seen   results
interface loss_min_tracker_if #(
  parameter int LOSS_W = 25,
  parameter int IDX_W  = 16
);
  logic              start;
  logic [IDX_W-1:0]  n_cand;
  logic              loss_valid;
  logic [LOSS_W-1:0] loss_in;
  logic              sweep_active;
  logic [LOSS_W-1:0] best_loss;
  logic [IDX_W-1:0]  best_idx;
  logic [IDX_W-1:0]  result_cnt;
  logic              done;
  logic              sat_seen;

  modport master (
    output start, n_cand, loss_valid, loss_in,
    input  sweep_active, best_loss, best_idx, result_cnt, done, sat_seen
  );

  modport slave (
    input  start, n_cand, loss_valid, loss_in,
    output sweep_active, best_loss, best_idx, result_cnt, done, sat_seen
  );
endinterface

// File: rtl/loss_min_tracker.sv
// loss_min_tracker
// Tracks the minimum loss (and the index of the candidate producing it)
// over a sweep of n_cand candidate parameter sets, then pulses done.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    loss_min_tracker_if.slave (start/n_cand in, loss_valid/loss_in in,
//          sweep_active/best_loss/best_idx/result_cnt/done/sat_seen out)
//
// state      | meaning
// -----------+--------------------------------------------------
// ST_IDLE    | waiting for start; results ignored
// ST_SWEEP   | accepting results, tracking minimum
// ST_DONE    | one-cycle done pulse, results held
module loss_min_tracker #(
  parameter int P      = 22,
  parameter int LOSS_W = 3 + P,
  parameter int IDX_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  loss_min_tracker_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [LOSS_W-1:0] LOSS_ONES = {LOSS_W{1'b1}};

  logic [1:0]        state;
  logic              valid_q;
  logic [IDX_W-1:0]  n_lat;
  logic [LOSS_W-1:0] best_loss;
  logic [IDX_W-1:0]  best_idx;
  logic [IDX_W-1:0]  result_cnt;
  logic              sat_seen;

  logic              accept;
  logic [IDX_W-1:0]  cnt_inc;

  // Only a rising edge of the strobe counts; valid_q follows loss_valid in
  // every state so a strobe already high at start is not taken as a result.
  assign accept  = bus.loss_valid & ~valid_q;
  assign cnt_inc = result_cnt + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.loss_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      n_lat      <= '0;
      best_loss  <= LOSS_ONES;
      best_idx   <= '0;
      result_cnt <= '0;
      sat_seen   <= 1'b0;
    end else if (bus.start) begin
      // start wins in every state; a result in the same cycle is dropped
      n_lat      <= bus.n_cand;
      best_loss  <= LOSS_ONES;
      best_idx   <= '0;
      result_cnt <= '0;
      sat_seen   <= 1'b0;
      state      <= (bus.n_cand == '0) ? ST_DONE : ST_SWEEP;
    end else begin
      case (state)
        ST_SWEEP: begin
          if (accept) begin
            // strict compare: ties keep the earlier index
            if (bus.loss_in < best_loss) begin
              best_loss <= bus.loss_in;
              best_idx  <= result_cnt;
            end
            if (bus.loss_in == LOSS_ONES) begin
              sat_seen <= 1'b1;
            end
            result_cnt <= cnt_inc;
            // ends before result_cnt could wrap, even for n_cand all-ones
            if (cnt_inc == n_lat) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.sweep_active = (state == ST_SWEEP);
  assign bus.done         = (state == ST_DONE);
  assign bus.best_loss    = best_loss;
  assign bus.best_idx     = best_idx;
  assign bus.result_cnt   = result_cnt;
  assign bus.sat_seen     = sat_seen;

endmodule

// File: tb/tb_loss_min_tracker.sv
module tb_loss_min_tracker;
  localparam int P      = 22;
  localparam int LOSS_W = 3 + P;
  localparam int IDX_W  = 16;
  localparam logic [LOSS_W-1:0] ONES = {LOSS_W{1'b1}};

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   done_seen;

  loss_min_tracker_if #(.LOSS_W(LOSS_W), .IDX_W(IDX_W)) bus ();

  loss_min_tracker #(.P(P), .LOSS_W(LOSS_W), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [IDX_W-1:0] n);
    bus.start  = 1'b1;
    bus.n_cand = n;
    tick();
    bus.start  = 1'b0;
  endtask

  // one low cycle, then a rising edge; returns just after the accepting edge
  task automatic pulse(input logic [LOSS_W-1:0] v);
    bus.loss_valid = 1'b0;
    tick();
    bus.loss_valid = 1'b1;
    bus.loss_in    = v;
    tick();
    bus.loss_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (bus.sweep_active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b want=0", bus.sweep_active); end
    total++; if (bus.best_loss !== ONES) begin bad++; $display("FAIL reset_best_loss got=%h want=%h", bus.best_loss, ONES); end
    total++; if (bus.best_idx !== 16'd0) begin bad++; $display("FAIL reset_best_idx got=%0d want=0", bus.best_idx); end
    total++; if (bus.result_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", bus.result_cnt); end
    total++; if (bus.done !== 1'b0 || bus.sat_seen !== 1'b0) begin bad++; $display("FAIL reset_done_sat got=%b%b want=00", bus.done, bus.sat_seen); end
    #5 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    do_start(16'd4);
    total++; if (bus.sweep_active !== 1'b1) begin bad++; $display("FAIL basic_active got=%b want=1", bus.sweep_active); end
    pulse(25'h100);
    total++; if (bus.best_loss !== 25'h100 || bus.best_idx !== 16'd0) begin bad++; $display("FAIL basic_r0 got=%h/%0d want=100/0", bus.best_loss, bus.best_idx); end
    pulse(25'h080);
    total++; if (bus.best_loss !== 25'h080 || bus.best_idx !== 16'd1) begin bad++; $display("FAIL basic_r1 got=%h/%0d want=080/1", bus.best_loss, bus.best_idx); end
    pulse(25'h0C0);
    total++; if (bus.result_cnt !== 16'd3 || bus.done !== 1'b0) begin bad++; $display("FAIL basic_r2 got=cnt%0d done%b want=cnt3 done0", bus.result_cnt, bus.done); end
    pulse(25'h080);
    total++; if (bus.best_loss !== 25'h080 || bus.best_idx !== 16'd1) begin bad++; $display("FAIL basic_tie got=%h/%0d want=080/1", bus.best_loss, bus.best_idx); end
    total++; if (bus.result_cnt !== 16'd4 || bus.done !== 1'b1 || bus.sweep_active !== 1'b0) begin bad++; $display("FAIL basic_done got=cnt%0d done%b act%b want=cnt4 done1 act0", bus.result_cnt, bus.done, bus.sweep_active); end
    tick();
    total++; if (bus.done !== 1'b0 || bus.sweep_active !== 1'b0 || bus.best_loss !== 25'h080) begin bad++; $display("FAIL basic_after got=done%b act%b best%h want=done0 act0 best080", bus.done, bus.sweep_active, bus.best_loss); end
  endtask

  task automatic test_held_valid();
    do_start(16'd2);
    bus.loss_in    = 25'h010;
    bus.loss_valid = 1'b1;
    repeat (5) tick();
    bus.loss_valid = 1'b0;
    total++; if (bus.result_cnt !== 16'd1 || bus.best_loss !== 25'h010 || bus.done !== 1'b0) begin bad++; $display("FAIL held_once got=cnt%0d best%h done%b want=cnt1 best010 done0", bus.result_cnt, bus.best_loss, bus.done); end
    pulse(25'h020);
    total++; if (bus.best_loss !== 25'h010 || bus.best_idx !== 16'd0 || bus.result_cnt !== 16'd2 || bus.done !== 1'b1) begin bad++; $display("FAIL held_end got=%h/%0d cnt%0d done%b want=010/0 cnt2 done1", bus.best_loss, bus.best_idx, bus.result_cnt, bus.done); end
    tick();
  endtask

  task automatic test_zero();
    do_start(16'd0);
    total++; if (bus.done !== 1'b1 || bus.sweep_active !== 1'b0) begin bad++; $display("FAIL zero_done got=done%b act%b want=done1 act0", bus.done, bus.sweep_active); end
    total++; if (bus.best_loss !== ONES || bus.best_idx !== 16'd0 || bus.result_cnt !== 16'd0) begin bad++; $display("FAIL zero_vals got=%h/%0d cnt%0d want=%h/0 cnt0", bus.best_loss, bus.best_idx, bus.result_cnt, ONES); end
    tick();
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL zero_once got=%b want=0", bus.done); end
  endtask

  task automatic test_restart();
    int d0;
    d0 = done_seen;
    do_start(16'd3);
    pulse(25'h050);
    pulse(25'h040);
    total++; if (bus.best_loss !== 25'h040 || bus.best_idx !== 16'd1 || bus.result_cnt !== 16'd2) begin bad++; $display("FAIL restart_mid got=%h/%0d cnt%0d want=040/1 cnt2", bus.best_loss, bus.best_idx, bus.result_cnt); end
    // restart with a result edge in the same cycle: the result is dropped
    bus.loss_valid = 1'b0;
    tick();
    bus.loss_valid = 1'b1;
    bus.loss_in    = 25'h030;
    do_start(16'd1);
    bus.loss_valid = 1'b0;
    total++; if (bus.result_cnt !== 16'd0 || bus.best_loss !== ONES || bus.sweep_active !== 1'b1 || bus.done !== 1'b0) begin bad++; $display("FAIL restart_clear got=cnt%0d best%h act%b done%b want=cnt0 best%h act1 done0", bus.result_cnt, bus.best_loss, bus.sweep_active, bus.done, ONES); end
    pulse(25'h060);
    total++; if (bus.best_loss !== 25'h060 || bus.best_idx !== 16'd0 || bus.done !== 1'b1) begin bad++; $display("FAIL restart_end got=%h/%0d done%b want=060/0 done1", bus.best_loss, bus.best_idx, bus.done); end
    tick();
    total++; if (done_seen - d0 !== 1) begin bad++; $display("FAIL restart_done_count got=%0d want=1", done_seen - d0); end
  endtask

  task automatic test_saturation();
    do_start(16'd3);
    pulse(ONES);
    total++; if (bus.best_loss !== ONES || bus.result_cnt !== 16'd1 || bus.sat_seen !== 1'b1) begin bad++; $display("FAIL sat_first got=%h cnt%0d sat%b want=%h cnt1 sat1", bus.best_loss, bus.result_cnt, bus.sat_seen, ONES); end
    pulse(25'h001);
    pulse(ONES);
    total++; if (bus.best_loss !== 25'h001 || bus.best_idx !== 16'd1 || bus.sat_seen !== 1'b1 || bus.done !== 1'b1) begin bad++; $display("FAIL sat_end got=%h/%0d sat%b done%b want=001/1 sat1 done1", bus.best_loss, bus.best_idx, bus.sat_seen, bus.done); end
    tick();
    do_start(16'd1);
    total++; if (bus.sat_seen !== 1'b0) begin bad++; $display("FAIL sat_clear got=%b want=0", bus.sat_seen); end
    pulse(25'h002);
    tick();
  endtask

  task automatic test_reset_mid();
    do_start(16'd5);
    pulse(25'h030);
    pulse(25'h020);
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.sweep_active !== 1'b0 || bus.best_loss !== ONES || bus.result_cnt !== 16'd0 || bus.best_idx !== 16'd0) begin bad++; $display("FAIL rstmid_vals got=act%b best%h cnt%0d idx%0d want=act0 best%h cnt0 idx0", bus.sweep_active, bus.best_loss, bus.result_cnt, bus.best_idx, ONES); end
    tick();
    rst_n = 1'b1;
    pulse(25'h010);
    pulse(25'h008);
    total++; if (bus.result_cnt !== 16'd0 || bus.best_loss !== ONES || bus.sweep_active !== 1'b0) begin bad++; $display("FAIL rstmid_ignore got=cnt%0d best%h act%b want=cnt0 best%h act0", bus.result_cnt, bus.best_loss, bus.sweep_active, ONES); end
    do_start(16'd1);
    pulse(25'h005);
    total++; if (bus.best_loss !== 25'h005 || bus.done !== 1'b1) begin bad++; $display("FAIL rstmid_resume got=%h done%b want=005 done1", bus.best_loss, bus.done); end
    tick();
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    done_seen      = 0;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.n_cand     = '0;
    bus.loss_valid = 1'b0;
    bus.loss_in    = '0;
    test_reset();
    test_basic();
    test_held_valid();
    test_zero();
    test_restart();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
